seven_segment_display_decoder: RTL and testbench

SEVEN_SEGMENT_DISPLAY_DECODER -- requirements
Module: seven_segment_display_decoder

---
 rtl/seven_segment_display_decoder.sv | 119 +++++++++++
 tb/tb_seven_segment_display_decoder.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/seven_segment_display_decoder.sv
// Purpose: recovers a 4-digit hex value by sampling a multiplexed, active-low 7-segment display bus.
// Latency: a pair held from cycle t is captured into value_o after edge t+STABLE_CYCLES+1.
// Backpressure: none; the display bus is free-running and every output is a plain register.
module seven_segment_display_decoder #(
   parameter int STABLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic        clk_i,
   input  logic        reset_btn_i,
   input  logic [3:0]  digital_select_i,
   input  logic [6:0]  seven_bit_display_i,
   output logic [15:0] value_o,
   output logic [3:0]  digit_valid_o,
   output logic        frame_valid_o,
   output logic        error_o,
   output logic        timeout_o
);

   localparam logic [7:0]  STABLE_C  = 8'(STABLE_CYCLES);
   localparam logic [23:0] TIMEOUT_C = 24'(TIMEOUT_CYCLES);

   logic [3:0]  sel_q, prev_sel;
   logic [6:0]  seg_q, prev_seg;
   logic [7:0]  stable_cnt, stable_nxt;
   logic [23:0] idle_cnt;
   logic        is_digit, same, capture, legal;
   logic [1:0]  digit_idx;
   logic [3:0]  nibble, dv_set;

   // Active-low segment pattern (g..a) to {legal, nibble}; anything not in the table is illegal.
   function automatic logic [4:0] decode(input logic [6:0] seg);
      case (seg)
         7'h40: decode = 5'h10;
         7'h79: decode = 5'h11;
         7'h24: decode = 5'h12;
         7'h30: decode = 5'h13;
         7'h19: decode = 5'h14;
         7'h12: decode = 5'h15;
         7'h02: decode = 5'h16;
         7'h78: decode = 5'h17;
         7'h00: decode = 5'h18;
         7'h10: decode = 5'h19;
         7'h08: decode = 5'h1A;
         7'h03: decode = 5'h1B;
         7'h46: decode = 5'h1C;
         7'h21: decode = 5'h1D;
         7'h06: decode = 5'h1E;
         7'h0E: decode = 5'h1F;
         default: decode = 5'h00;
      endcase
   endfunction

   // Classify the registered sample, advance the stability count and detect the single capture point.
   always_comb begin
      is_digit  = $onehot(~sel_q);
      same      = (sel_q == prev_sel) && (seg_q == prev_seg);
      digit_idx = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (!sel_q[i]) digit_idx = 2'(i);
      end
      stable_nxt = stable_cnt;
      if (!is_digit)                  stable_nxt = 8'd0;
      else if (!same)                 stable_nxt = 8'd1;
      else if (stable_cnt != STABLE_C) stable_nxt = stable_cnt + 8'd1;
      // The count saturates at STABLE_CYCLES, so "already there and unchanged" means this run was captured.
      capture = is_digit && (stable_nxt == STABLE_C) && !(same && (stable_cnt == STABLE_C));
      {legal, nibble} = decode(seg_q);
      dv_set = digit_valid_o | (4'b0001 << digit_idx);
   end

   // Input sampling, capture bookkeeping, frame assembly and idle timeout; reset overrides everything.
   always_ff @(posedge clk_i) begin
      if (reset_btn_i) begin
         sel_q         <= '0;
         seg_q         <= '0;
         prev_sel      <= '0;
         prev_seg      <= '0;
         stable_cnt    <= '0;
         idle_cnt      <= '0;
         value_o       <= '0;
         digit_valid_o <= '0;
         frame_valid_o <= 1'b0;
         error_o       <= 1'b0;
         timeout_o     <= 1'b0;
      end else begin
         sel_q         <= digital_select_i;
         seg_q         <= seven_bit_display_i;
         prev_sel      <= sel_q;
         prev_seg      <= seg_q;
         stable_cnt    <= stable_nxt;
         frame_valid_o <= 1'b0;
         if (capture) begin
            // A capture restarts the idle window and wins over a coincident timeout.
            idle_cnt  <= '0;
            timeout_o <= 1'b0;
            if (legal) begin
               value_o[{digit_idx, 2'b00} +: 4] <= nibble;
               if (dv_set == 4'hF) begin
                  frame_valid_o <= 1'b1;
                  digit_valid_o <= 4'h0;
               end else begin
                  digit_valid_o <= dv_set;
               end
            end else begin
               digit_valid_o[digit_idx] <= 1'b0;
               error_o                  <= 1'b1;
            end
         end else begin
            if (idle_cnt != TIMEOUT_C) idle_cnt <= idle_cnt + 24'd1;
            // Timeout asserts on the edge where the counter arrives at TIMEOUT_CYCLES and stays set.
            if (idle_cnt >= TIMEOUT_C - 24'd1) begin
               timeout_o     <= 1'b1;
               digit_valid_o <= 4'h0;
            end
         end
      end
   end

endmodule

// File: tb/tb_seven_segment_display_decoder.sv
// Purpose: directed self-checking bench for seven_segment_display_decoder (STABLE_CYCLES=4, TIMEOUT_CYCLES=20).
// Latency: inputs change 1 time unit after a rising edge; outputs are sampled at the same offset.
// Backpressure: not applicable; the bench drives the display bus freely.
module tb_seven_segment_display_decoder;

   logic        clk_i = 1'b0;
   logic        reset_btn_i = 1'b1;
   logic [3:0]  digital_select_i = 4'hF;
   logic [6:0]  seven_bit_display_i = 7'h7F;
   logic [15:0] value_o;
   logic [3:0]  digit_valid_o;
   logic        frame_valid_o, error_o, timeout_o;
   int          total = 0;
   int          bad = 0;

   seven_segment_display_decoder #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(20)) dut (
      .clk_i(clk_i), .reset_btn_i(reset_btn_i), .digital_select_i(digital_select_i),
      .seven_bit_display_i(seven_bit_display_i), .value_o(value_o), .digit_valid_o(digit_valid_o),
      .frame_valid_o(frame_valid_o), .error_o(error_o), .timeout_o(timeout_o));

   always #5 clk_i = ~clk_i;

   // Present a (select, segments) pair for n rising edges; returns 1 time unit after the last edge.
   task automatic hold(input logic [3:0] sel, input logic [6:0] seg, input int n);
      digital_select_i    = sel;
      seven_bit_display_i = seg;
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic do_reset();
      reset_btn_i = 1'b1;
      hold(4'hF, 7'h7F, 1);
      reset_btn_i = 1'b0;
   endtask

   task automatic test_reset();
      hold(4'hE, 7'h24, 3);
      do_reset();
      total++; if (value_o !== 16'h0000) begin bad++; $display("FAIL reset_value got=%h want=0000", value_o); end
      total++; if (digit_valid_o !== 4'h0) begin bad++; $display("FAIL reset_dv got=%b want=0000", digit_valid_o); end
      total++; if (frame_valid_o !== 1'b0) begin bad++; $display("FAIL reset_frame got=%b want=0", frame_valid_o); end
      total++; if (error_o !== 1'b0) begin bad++; $display("FAIL reset_error got=%b want=0", error_o); end
      total++; if (timeout_o !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b want=0", timeout_o); end
   endtask

   task automatic test_capture();
      do_reset();
      hold(4'hE, 7'h24, 4);
      total++; if (digit_valid_o !== 4'h0) begin bad++; $display("FAIL cap_early_dv got=%b want=0000", digit_valid_o); end
      hold(4'hE, 7'h24, 1);
      total++; if (value_o[3:0] !== 4'h2) begin bad++; $display("FAIL cap_value got=%h want=2", value_o[3:0]); end
      total++; if (digit_valid_o !== 4'b0001) begin bad++; $display("FAIL cap_dv got=%b want=0001", digit_valid_o); end
      hold(4'hD, 7'h79, 3);
      hold(4'hF, 7'h7F, 3);
      total++; if (value_o !== 16'h0002) begin bad++; $display("FAIL short_hold_value got=%h want=0002", value_o); end
      total++; if (digit_valid_o !== 4'b0001) begin bad++; $display("FAIL short_hold_dv got=%b want=0001", digit_valid_o); end
   endtask

   task automatic test_frame();
      do_reset();
      hold(4'hE, 7'h30, 6);
      hold(4'hD, 7'h19, 6);
      hold(4'hB, 7'h12, 6);
      total++; if (digit_valid_o !== 4'b0111) begin bad++; $display("FAIL frame_partial_dv got=%b want=0111", digit_valid_o); end
      hold(4'h7, 7'h02, 4);
      total++; if (frame_valid_o !== 1'b0) begin bad++; $display("FAIL frame_early got=%b want=0", frame_valid_o); end
      hold(4'h7, 7'h02, 1);
      total++; if (frame_valid_o !== 1'b1) begin bad++; $display("FAIL frame_pulse got=%b want=1", frame_valid_o); end
      total++; if (digit_valid_o !== 4'h0) begin bad++; $display("FAIL frame_dv got=%b want=0000", digit_valid_o); end
      total++; if (value_o !== 16'h6543) begin bad++; $display("FAIL frame_value got=%h want=6543", value_o); end
      hold(4'h7, 7'h02, 1);
      total++; if (frame_valid_o !== 1'b0) begin bad++; $display("FAIL frame_one_cycle got=%b want=0", frame_valid_o); end
      hold(4'h7, 7'h02, 3);
      total++; if (digit_valid_o !== 4'h0) begin bad++; $display("FAIL frame_no_recap got=%b want=0000", digit_valid_o); end
   endtask

   task automatic test_overwrite();
      do_reset();
      hold(4'hE, 7'h30, 6);
      hold(4'hE, 7'h19, 6);
      total++; if (value_o !== 16'h0004) begin bad++; $display("FAIL overwrite_value got=%h want=0004", value_o); end
      total++; if (digit_valid_o !== 4'b0001) begin bad++; $display("FAIL overwrite_dv got=%b want=0001", digit_valid_o); end
      total++; if (frame_valid_o !== 1'b0) begin bad++; $display("FAIL overwrite_frame got=%b want=0", frame_valid_o); end
   endtask

   task automatic test_error();
      do_reset();
      hold(4'hB, 7'h12, 6);
      total++; if (error_o !== 1'b0) begin bad++; $display("FAIL err_before got=%b want=0", error_o); end
      hold(4'hB, 7'h7F, 6);
      total++; if (error_o !== 1'b1) begin bad++; $display("FAIL err_set got=%b want=1", error_o); end
      total++; if (value_o !== 16'h0500) begin bad++; $display("FAIL err_value got=%h want=0500", value_o); end
      total++; if (digit_valid_o !== 4'h0) begin bad++; $display("FAIL err_dv got=%b want=0000", digit_valid_o); end
      hold(4'hE, 7'h40, 6);
      total++; if (error_o !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", error_o); end
      total++; if (digit_valid_o !== 4'b0001) begin bad++; $display("FAIL err_then_legal got=%b want=0001", digit_valid_o); end
   endtask

   task automatic test_timeout();
      do_reset();
      hold(4'hE, 7'h79, 5);
      hold(4'hF, 7'h7F, 10);
      hold(4'h9, 7'h7F, 9);
      total++; if (timeout_o !== 1'b0) begin bad++; $display("FAIL to_early got=%b want=0", timeout_o); end
      total++; if (digit_valid_o !== 4'b0001) begin bad++; $display("FAIL to_early_dv got=%b want=0001", digit_valid_o); end
      hold(4'h9, 7'h7F, 1);
      total++; if (timeout_o !== 1'b1) begin bad++; $display("FAIL to_set got=%b want=1", timeout_o); end
      total++; if (digit_valid_o !== 4'h0) begin bad++; $display("FAIL to_dv got=%b want=0000", digit_valid_o); end
      total++; if (value_o !== 16'h0001) begin bad++; $display("FAIL to_value got=%h want=0001", value_o); end
      hold(4'hD, 7'h24, 4);
      total++; if (timeout_o !== 1'b1) begin bad++; $display("FAIL to_hold got=%b want=1", timeout_o); end
      hold(4'hD, 7'h24, 1);
      total++; if (timeout_o !== 1'b0) begin bad++; $display("FAIL to_clear got=%b want=0", timeout_o); end
      total++; if (value_o !== 16'h0021) begin bad++; $display("FAIL to_recap_value got=%h want=0021", value_o); end
   endtask

   task automatic test_reset_mid_frame();
      do_reset();
      hold(4'hE, 7'h30, 6);
      hold(4'hD, 7'h19, 6);
      hold(4'hB, 7'h12, 6);
      do_reset();
      total++; if (value_o !== 16'h0000) begin bad++; $display("FAIL mid_reset_value got=%h want=0000", value_o); end
      total++; if (digit_valid_o !== 4'h0) begin bad++; $display("FAIL mid_reset_dv got=%b want=0000", digit_valid_o); end
      hold(4'h7, 7'h02, 5);
      total++; if (frame_valid_o !== 1'b0) begin bad++; $display("FAIL mid_reset_noframe got=%b want=0", frame_valid_o); end
      total++; if (digit_valid_o !== 4'b1000) begin bad++; $display("FAIL mid_reset_dv3 got=%b want=1000", digit_valid_o); end
      hold(4'h7, 7'h02, 1);
      hold(4'hE, 7'h30, 6);
      hold(4'hD, 7'h19, 6);
      hold(4'hB, 7'h12, 5);
      total++; if (frame_valid_o !== 1'b1) begin bad++; $display("FAIL mid_reset_frame got=%b want=1", frame_valid_o); end
      total++; if (value_o !== 16'h6543) begin bad++; $display("FAIL mid_reset_full got=%h want=6543", value_o); end
   endtask

   initial begin
      test_reset();
      test_capture();
      test_frame();
      test_overwrite();
      test_error();
      test_timeout();
      test_reset_mid_frame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
